sync_pack_fifo: RTL and testbench

- Parametrised synchronous width-converting FIFO: narrow writes (e.g. UART bytes) are packed into wide words and stored; wide words are read out.
- Generalises the fixed 8-to-256 SYN_FIFO in the UART-to-accelerator path with:
  - a configurable width ratio and lane order;
  - a partial-word flush with padding;
  - sticky overflow/underflow flags and a read-valid strobe.
- Sits between the UART receiver and the wide DDR/accelerator write port.

---
 rtl/sync_pack_fifo_pkg.sv | 30 +++
 rtl/fifo_packer.sv | 79 +++++++
 rtl/sync_pack_fifo.sv | 125 ++++++++++++
 tb/tb_sync_pack_fifo.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sync_pack_fifo_pkg.sv
// Shared constants and width helpers for the packing FIFO.
// Lane-order selectors are fixed-length string constants so they compare as plain vectors.
package sync_pack_fifo_pkg;

    typedef logic [8*9-1:0] lane_order_t;

    localparam lane_order_t LANE_LSB_FIRST = "LSB_FIRST";
    localparam lane_order_t LANE_MSB_FIRST = "MSB_FIRST";

    function automatic int clog2(input int unsigned value);
        int unsigned v;
        int          result;
        v      = (value > 0) ? value - 1 : 0;
        result = 0;
        while (v != 0) begin
            result++;
            v = v >> 1;
        end
        return result;
    endfunction

    function automatic int calc_rd_width(input int unsigned wr_width, input int unsigned ratio);
        return int'(wr_width * ratio);
    endfunction

    function automatic int calc_lane_w(input int unsigned ratio);
        return clog2(ratio);
    endfunction

endpackage

// File: rtl/fifo_packer.sv
// Assembles narrow writes into one wide word and raises a push when the word
// completes or when a flush pads out a partially filled word.
module fifo_packer
    import sync_pack_fifo_pkg::*;
#(
    parameter int unsigned          WR_WIDTH   = 8,
    parameter int unsigned          RATIO      = 32,
    parameter lane_order_t          LANE_ORDER = LANE_LSB_FIRST,
    parameter logic [WR_WIDTH-1:0]  PAD_VALUE  = '0,
    localparam int                  RD_WIDTH   = calc_rd_width(WR_WIDTH, RATIO),
    localparam int                  LANE_W     = calc_lane_w(RATIO)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [WR_WIDTH-1:0] i_wr_data,
    input  logic                i_wr_en,
    input  logic                i_flush,
    input  logic                i_full,
    output logic                o_push_valid,
    output logic [RD_WIDTH-1:0] o_push_word,
    output logic [LANE_W-1:0]   o_lane_cnt
);

    localparam bit                MSB_FIRST = (LANE_ORDER == LANE_MSB_FIRST);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(RATIO - 1);

    logic [LANE_W-1:0]   r_lane_cnt;
    logic [LANE_W-1:0]   w_lane_next;
    logic [RD_WIDTH-1:0] r_word;
    logic [RD_WIDTH-1:0] w_word_wr;
    logic [RD_WIDTH-1:0] w_word_pad;
    logic                w_wr_acc;
    logic                w_complete;
    logic                w_flush_acc;

    function automatic int phys_lane(input int j);
        return MSB_FIRST ? int'(RATIO) - 1 - j : j;
    endfunction

    assign w_wr_acc    = i_wr_en & ~i_full;
    assign w_complete  = w_wr_acc & (r_lane_cnt == LAST_LANE);
    assign w_lane_next = w_wr_acc ? r_lane_cnt + 1'b1 : r_lane_cnt;
    // A write that completes the word leaves w_lane_next at 0, so a same-cycle flush falls away.
    assign w_flush_acc = i_flush & ~i_full & (w_lane_next != '0);

    // NOTE: every always_comb output gets a full default first so no latch can be inferred.
    always_comb begin
        w_word_wr  = r_word;
        w_word_pad = '0;
        for (int j = 0; j < int'(RATIO); j++) begin
            if (w_wr_acc && (r_lane_cnt == LANE_W'(j)))
                w_word_wr[phys_lane(j)*WR_WIDTH +: WR_WIDTH] = i_wr_data;
        end
        for (int j = 0; j < int'(RATIO); j++) begin
            w_word_pad[phys_lane(j)*WR_WIDTH +: WR_WIDTH] =
                (LANE_W'(j) < w_lane_next) ? w_word_wr[phys_lane(j)*WR_WIDTH +: WR_WIDTH]
                                           : PAD_VALUE;
        end
    end

    assign o_push_valid = w_complete | w_flush_acc;
    assign o_push_word  = w_complete ? w_word_wr : w_word_pad;
    assign o_lane_cnt   = r_lane_cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lane_cnt <= '0;
            r_word     <= '0;
        end else begin
            r_lane_cnt <= w_flush_acc ? '0 : w_lane_next;
            if (o_push_valid)
                r_word <= '0;
            else if (w_wr_acc)
                r_word <= w_word_wr;
        end
    end

endmodule

// File: rtl/sync_pack_fifo.sv
// Width-converting FIFO: narrow writes are packed into wide words, stored in a
// simple dual-port RAM and read out wide, with level flags and sticky errors.
module sync_pack_fifo
    import sync_pack_fifo_pkg::*;
#(
    parameter int unsigned          WR_WIDTH         = 8,
    parameter int unsigned          RATIO            = 32,
    parameter int unsigned          RD_DEPTH_WIDTH   = 5,
    parameter int unsigned          ALMOST_FULL_NUM  = 1000,
    parameter int unsigned          ALMOST_EMPTY_NUM = 4,
    parameter lane_order_t          LANE_ORDER       = LANE_LSB_FIRST,
    parameter logic [WR_WIDTH-1:0]  PAD_VALUE        = '0,
    localparam int                  RD_WIDTH         = calc_rd_width(WR_WIDTH, RATIO),
    localparam int                  LANE_W           = calc_lane_w(RATIO)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [WR_WIDTH-1:0]              i_wr_data,
    input  logic                             i_wr_en,
    input  logic                             i_flush,
    output logic                             o_wr_full,
    output logic [RD_DEPTH_WIDTH+LANE_W:0]   o_wr_water_level,
    output logic                             o_almost_full,
    output logic                             o_wr_ovf,
    input  logic                             i_rd_en,
    output logic [RD_WIDTH-1:0]              o_rd_data,
    output logic                             o_rd_valid,
    output logic                             o_rd_empty,
    output logic [RD_DEPTH_WIDTH:0]          o_rd_water_level,
    output logic                             o_almost_empty,
    output logic                             o_rd_udf
);

    localparam int unsigned DEPTH = 2 ** RD_DEPTH_WIDTH;

    logic [1:0]                r_rst_sync;
    logic                      w_rst_n;
    logic [RD_DEPTH_WIDTH:0]   r_wr_ptr;
    logic [RD_DEPTH_WIDTH:0]   r_rd_ptr;
    logic [RD_WIDTH-1:0]       r_mem [DEPTH];
    logic [RD_WIDTH-1:0]       r_rd_data;
    logic                      r_rd_valid;
    logic                      r_wr_ovf;
    logic                      r_rd_udf;
    logic                      w_push_valid;
    logic [RD_WIDTH-1:0]       w_push_word;
    logic [LANE_W-1:0]         w_lane_cnt;
    logic                      w_full;
    logic                      w_empty;
    logic                      w_rd_acc;
    logic [RD_DEPTH_WIDTH:0]   w_rd_level;

    // Assert immediately, release two clock edges after rst_n rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_rst_sync <= '0;
        else
            r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_rst_n = r_rst_sync[1];

    fifo_packer #(
        .WR_WIDTH   (WR_WIDTH),
        .RATIO      (RATIO),
        .LANE_ORDER (LANE_ORDER),
        .PAD_VALUE  (PAD_VALUE)
    ) u_packer (
        .clk          (clk),
        .rst_n        (w_rst_n),
        .i_wr_data    (i_wr_data),
        .i_wr_en      (i_wr_en),
        .i_flush      (i_flush),
        .i_full       (w_full),
        .o_push_valid (w_push_valid),
        .o_push_word  (w_push_word),
        .o_lane_cnt   (w_lane_cnt)
    );

    assign w_full     = (r_wr_ptr[RD_DEPTH_WIDTH] != r_rd_ptr[RD_DEPTH_WIDTH]) &&
                        (r_wr_ptr[RD_DEPTH_WIDTH-1:0] == r_rd_ptr[RD_DEPTH_WIDTH-1:0]);
    assign w_empty    = (r_wr_ptr == r_rd_ptr);
    assign w_rd_acc   = i_rd_en & ~w_empty;
    assign w_rd_level = r_wr_ptr - r_rd_ptr;

    // NOTE: the storage array has no reset; the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (w_push_valid)
            r_mem[r_wr_ptr[RD_DEPTH_WIDTH-1:0]] <= w_push_word;
    end

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
            r_wr_ovf   <= 1'b0;
            r_rd_udf   <= 1'b0;
        end else begin
            if (w_push_valid)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd_acc) begin
                r_rd_ptr  <= r_rd_ptr + 1'b1;
                r_rd_data <= r_mem[r_rd_ptr[RD_DEPTH_WIDTH-1:0]];
            end
            r_rd_valid <= w_rd_acc;
            if (w_full && (i_wr_en || (i_flush && (w_lane_cnt != '0))))
                r_wr_ovf <= 1'b1;
            if (i_rd_en && w_empty)
                r_rd_udf <= 1'b1;
        end
    end

    assign o_wr_full        = w_full;
    assign o_rd_empty       = w_empty;
    assign o_rd_water_level = w_rd_level;
    assign o_wr_water_level = {w_rd_level, w_lane_cnt};
    assign o_almost_full    = (32'(o_wr_water_level) >= ALMOST_FULL_NUM);
    assign o_almost_empty   = (32'(w_rd_level) <= ALMOST_EMPTY_NUM);
    assign o_rd_data        = r_rd_data;
    assign o_rd_valid       = r_rd_valid;
    assign o_wr_ovf         = r_wr_ovf;
    assign o_rd_udf         = r_rd_udf;

endmodule

// File: tb/tb_sync_pack_fifo.sv
// Self-checking bench for sync_pack_fifo at default parameters, with a second
// MSB_FIRST instance sharing the stimulus; expectations come from a queue model.
module tb_sync_pack_fifo;

    localparam int RATIO = 32;
    localparam int DEPTH = 32;
    localparam int RD_W  = 256;
    localparam int AF    = 1000;
    localparam int AE    = 4;

    logic            clk;
    logic            rst_n;
    logic [7:0]      wr_data;
    logic            wr_en;
    logic            flush;
    logic            rd_en;

    logic            wr_full,  m_wr_full;
    logic [10:0]     wr_lvl,   m_wr_lvl;
    logic            alm_full, m_alm_full;
    logic            wr_ovf,   m_wr_ovf;
    logic [RD_W-1:0] rd_data,  m_rd_data_o;
    logic            rd_valid, m_rd_valid_o;
    logic            rd_empty, m_rd_empty;
    logic [5:0]      rd_lvl,   m_rd_lvl;
    logic            alm_empty, m_alm_empty;
    logic            rd_udf,   m_rd_udf_o;

    sync_pack_fifo u_dut (
        .clk (clk), .rst_n (rst_n),
        .i_wr_data (wr_data), .i_wr_en (wr_en), .i_flush (flush),
        .o_wr_full (wr_full), .o_wr_water_level (wr_lvl), .o_almost_full (alm_full),
        .o_wr_ovf (wr_ovf), .i_rd_en (rd_en), .o_rd_data (rd_data), .o_rd_valid (rd_valid),
        .o_rd_empty (rd_empty), .o_rd_water_level (rd_lvl), .o_almost_empty (alm_empty),
        .o_rd_udf (rd_udf)
    );

    sync_pack_fifo #(.LANE_ORDER("MSB_FIRST")) u_dut_msb (
        .clk (clk), .rst_n (rst_n),
        .i_wr_data (wr_data), .i_wr_en (wr_en), .i_flush (flush),
        .o_wr_full (m_wr_full), .o_wr_water_level (m_wr_lvl), .o_almost_full (m_alm_full),
        .o_wr_ovf (m_wr_ovf), .i_rd_en (rd_en), .o_rd_data (m_rd_data_o),
        .o_rd_valid (m_rd_valid_o), .o_rd_empty (m_rd_empty), .o_rd_water_level (m_rd_lvl),
        .o_almost_empty (m_alm_empty), .o_rd_udf (m_rd_udf_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: stored wide words as queues, the partial word as a byte queue.
    logic [RD_W-1:0] q_lsb [$];
    logic [RD_W-1:0] q_msb [$];
    logic [7:0]      part  [$];
    logic            e_ovf, e_udf, e_valid;
    logic [RD_W-1:0] e_data, e_data_msb;

    task automatic check(input string name, input logic [RD_W-1:0] act, input logic [RD_W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [RD_W-1:0] pack_word(input bit msb);
        logic [RD_W-1:0] w;
        int              lane;
        w = '0;
        for (int i = 0; i < RATIO; i++) begin
            lane = msb ? RATIO - 1 - i : i;
            w[lane*8 +: 8] = (i < part.size()) ? part[i] : 8'h00;
        end
        return w;
    endfunction

    task automatic push_part();
        q_lsb.push_back(pack_word(1'b0));
        q_msb.push_back(pack_word(1'b1));
        part.delete();
    endtask

    task automatic model_reset();
        q_lsb.delete(); q_msb.delete(); part.delete();
        e_ovf = 0; e_udf = 0; e_valid = 0; e_data = '0; e_data_msb = '0;
    endtask

    task automatic model_step(input bit we, input logic [7:0] wd, input bit fl, input bit re);
        int cnt;
        bit full_pre, empty_pre;
        cnt       = q_lsb.size();
        full_pre  = (cnt == DEPTH);
        empty_pre = (cnt == 0);
        e_valid   = 0;
        if (re) begin
            if (empty_pre) e_udf = 1;
            else begin
                e_data     = q_lsb.pop_front();
                e_data_msb = q_msb.pop_front();
                e_valid    = 1;
            end
        end
        if (we) begin
            if (full_pre) e_ovf = 1;
            else begin
                part.push_back(wd);
                if (part.size() == RATIO) push_part();
            end
        end
        if (fl && part.size() != 0) begin
            if (full_pre) e_ovf = 1;
            else push_part();
        end
    endtask

    task automatic check_model();
        int         cnt, wl;
        logic [6:0] ef;
        cnt = q_lsb.size();
        wl  = cnt * RATIO + part.size();
        ef  = {cnt == DEPTH, cnt == 0, wl >= AF, cnt <= AE, e_ovf, e_udf, e_valid};
        check("rd_water_level", rd_lvl, cnt);
        check("wr_water_level", wr_lvl, wl);
        check("flags{full,empty,af,ae,ovf,udf,valid}",
              {wr_full, rd_empty, alm_full, alm_empty, wr_ovf, rd_udf, rd_valid}, ef);
        check("rd_data", rd_data, e_data);
        check("msb_flags", {m_wr_full, m_rd_empty, m_alm_full, m_alm_empty, m_wr_ovf,
                            m_rd_udf_o, m_rd_valid_o}, ef);
        check("msb_levels", {m_wr_lvl, m_rd_lvl}, {11'(wl), 6'(cnt)});
        check("msb_rd_data", m_rd_data_o, e_data_msb);
    endtask

    task automatic cycle(input bit we, input logic [7:0] wd, input bit fl, input bit re);
        wr_en = we; wr_data = wd; flush = fl; rd_en = re;
        @(posedge clk);
        model_step(we, wd, fl, re);
        #1;
        check_model();
        wr_en = 0; flush = 0; rd_en = 0;
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    typedef struct {
        bit              we;
        logic [7:0]      wd;
        bit              fl;
        bit              re;
        int              rd_lvl;
        int              wr_lvl;
        bit              empty;
        bit              valid;
        logic [RD_W-1:0] data;
    } vec_t;

    vec_t tbl [8];

    initial begin
        logic [RD_W-1:0] k_seq;
        logic [RD_W-1:0] k_seq_msb;

        tbl[0] = '{1, 8'hA1, 0, 0, 0,  1, 1, 0, '0};
        tbl[1] = '{1, 8'hA2, 0, 0, 0,  2, 1, 0, '0};
        tbl[2] = '{1, 8'hA3, 0, 0, 0,  3, 1, 0, '0};
        tbl[3] = '{1, 8'hA4, 0, 0, 0,  4, 1, 0, '0};
        tbl[4] = '{1, 8'hA5, 0, 0, 0,  5, 1, 0, '0};
        tbl[5] = '{0, 8'h00, 1, 0, 1, 32, 0, 0, '0};
        tbl[6] = '{0, 8'h00, 0, 1, 0,  0, 1, 1, 256'hA5A4A3A2A1};
        tbl[7] = '{0, 8'h00, 0, 0, 0,  0, 1, 0, 256'hA5A4A3A2A1};
        k_seq     = 256'h1F1E1D1C1B1A191817161514131211100F0E0D0C0B0A09080706050403020100;
        k_seq_msb = 256'h000102030405060708090A0B0C0D0E0F101112131415161718191A1B1C1D1E1F;

        wr_en = 0; wr_data = '0; flush = 0; rd_en = 0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        model_reset();
        #2;
        check_model();
        release_reset();
        check_model();

        // Partial word A1..A5 flushed with zero padding, then read out.
        foreach (tbl[i]) begin
            cycle(tbl[i].we, tbl[i].wd, tbl[i].fl, tbl[i].re);
            check($sformatf("tbl%0d_rd_lvl", i), rd_lvl, tbl[i].rd_lvl);
            check($sformatf("tbl%0d_wr_lvl", i), wr_lvl, tbl[i].wr_lvl);
            check($sformatf("tbl%0d_empty", i), rd_empty, tbl[i].empty);
            check($sformatf("tbl%0d_valid", i), rd_valid, tbl[i].valid);
            check($sformatf("tbl%0d_data", i), rd_data, tbl[i].data);
        end

        // Read while empty is rejected and the underflow flag sticks.
        cycle(0, 8'h00, 0, 1);
        check("udf_valid", rd_valid, 0);
        check("udf_set", rd_udf, 1);
        repeat (3) cycle(0, 8'h00, 0, 0);
        check("udf_sticky", rd_udf, 1);

        // Bytes 0x00..0x1F fill one word in both lane orders.
        for (int i = 0; i < 32; i++) begin
            cycle(1, 8'(i), 0, 0);
            if (i == 30) check("empty_before_32nd", rd_empty, 1);
        end
        check("empty_after_32nd", rd_empty, 0);
        cycle(0, 8'h00, 0, 1);
        check("seq_valid", rd_valid, 1);
        check("seq_lsb_data", rd_data, k_seq);
        check("seq_msb_data", m_rd_data_o, k_seq_msb);

        // Same-cycle push and pop with one word stored and the packer one byte short.
        for (int i = 0; i < 63; i++) cycle(1, 8'($urandom), 0, 0);
        check("pp_pre_lvl", wr_lvl, 63);
        cycle(1, 8'h5C, 0, 1);
        check("pp_rd_lvl", rd_lvl, 1);
        check("pp_valid", rd_valid, 1);
        cycle(0, 8'h00, 0, 1);
        check("pp_second_valid", rd_valid, 1);

        // Fill to full: almost_full threshold, flush no-op, overflow.
        for (int i = 0; i < 1024; i++) begin
            cycle(1, 8'($urandom), 0, 0);
            if (i == 998) check("af_below", alm_full, 0);
            if (i == 999) check("af_at_1000", alm_full, 1);
        end
        check("full_set", wr_full, 1);
        check("full_lvl", wr_lvl, 1024);
        cycle(0, 8'h00, 1, 0);
        check("flush_lane0_no_ovf", wr_ovf, 0);
        cycle(1, 8'hEE, 0, 0);
        check("ovf_set", wr_ovf, 1);
        check("ovf_lvl", wr_lvl, 1024);
        cycle(1, 8'hEF, 0, 1);
        check("full_rw_lvl", wr_lvl, 992);
        for (int i = 0; i < 31; i++) cycle(0, 8'h00, 0, 1);
        check("drained", rd_empty, 1);

        // Asynchronous reset between clock edges with data and errors present.
        for (int i = 0; i < 323; i++) cycle(1, 8'($urandom), 0, 0);
        check("pre_rst_wl", wr_lvl, 323);
        check("pre_rst_ovf", wr_ovf, 1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("arst_flags{full,empty,af,ae,ovf,udf,valid}",
              {wr_full, rd_empty, alm_full, alm_empty, wr_ovf, rd_udf, rd_valid}, 7'b0101000);
        check("arst_levels", {wr_lvl, rd_lvl}, 17'd0);
        check("arst_rd_data", rd_data, '0);
        model_reset();
        release_reset();
        cycle(0, 8'h00, 0, 1);
        check("post_rst_read_valid", rd_valid, 0);
        check("post_rst_read_udf", rd_udf, 1);

        // Random traffic alternating fill-heavy and drain-heavy phases.
        for (int p = 0; p < 4; p++) begin
            int wp, rp, n;
            wp = (p % 2 == 0) ? 90 : 30;
            rp = (p % 2 == 0) ? 1 : 60;
            n  = (p % 2 == 0) ? 1500 : 600;
            for (int i = 0; i < n; i++)
                cycle($urandom_range(0, 99) < wp, 8'($urandom),
                      $urandom_range(0, 99) < 3, $urandom_range(0, 99) < rp);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
